if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on posedge.
REQ-003 rst_n_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 keep_if_id_i  input  1  SHALL mean the downstream fetch/decode register is stalled and does not accept this cycle.
REQ-005 redirect_i  input  1  SHALL mean a taken branch or jump resolved downstream; it flushes fetch.
REQ-006 redirect_pc_i  input  32  SHALL be the redirect target.
REQ-007 imem_req_o  output  1  SHALL be the instruction memory request strobe, accepted by memory in the same cycle.
REQ-008 imem_addr_o  output  32  SHALL be the fetch address and is meaningful only while imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  SHALL mean the read data is valid, at least 1 cycle after the request; one request is outstanding at most.
REQ-010 imem_rdata_i  input  32  SHALL be the instruction word.
REQ-011 inst_o  output  32  SHALL be the fetched instruction presented to the decode register.
REQ-012 pc_o  output  32  SHALL be the PC of inst_o.
REQ-013 null_o  output  1  SHALL be 1 when inst_o/pc_o carry no valid instruction (bubble).

Function
REQ-014 State machine SHALL have states IDLE, REQ, WAIT and HOLD, with internal regs fetch_pc, kill, and output buffer inst_q/pc_q/valid_q.
REQ-015 Outputs SHALL be registered: inst_o=inst_q, pc_o=pc_q, null_o=~valid_q.
REQ-016 An instruction SHALL transfer downstream in a cycle where null_o=0 and keep_if_id_i=0.
REQ-017 IDLE SHALL go to REQ unconditionally on the first clock after reset release.
REQ-018 REQ SHALL drive imem_req_o=1 and imem_addr_o=fetch_pc, then go to WAIT.
REQ-019 WAIT with imem_rvalid_i=1 and kill=0 SHALL load inst_q=imem_rdata_i, pc_q=fetch_pc and valid_q=1, then go to HOLD.
REQ-020 WAIT with imem_rvalid_i=1 and kill=1 SHALL discard the data, clear kill and go to REQ.
REQ-021 HOLD with keep_if_id_i=1 SHALL leave all state unchanged, and the buffer SHALL stay stable for any number of stall cycles.
REQ-022 In HOLD with keep_if_id_i=0, the instruction transfers.
  - Same cycle: imem_req_o=1 and imem_addr_o=fetch_pc+4.
  - Next clock: fetch_pc<=fetch_pc+4, valid_q<=0, go to WAIT.
  - Throughput SHALL be one instruction per (memory latency + 1) cycles.
REQ-023 Redirect SHALL have priority over every other event in every state.
  - fetch_pc<=redirect_pc_i with bits[1:0] forced to 0.
  - valid_q<=0, so null_o=1 on the next cycle.
  - imem_req_o SHALL be forced to 0 in the redirect cycle.
REQ-024 Redirect in WAIT without imem_rvalid_i SHALL set kill and remain in WAIT.
REQ-025 Redirect in WAIT with imem_rvalid_i in the same cycle SHALL discard the data and go to REQ.
REQ-026 Redirect in IDLE, REQ or HOLD SHALL go to REQ.
REQ-027 A redirect in HOLD with keep_if_id_i=1 SHALL still drop the held instruction.
REQ-028 A second redirect while kill=1 SHALL update fetch_pc and keep kill=1.
REQ-029 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-030 imem_rvalid_i in IDLE, REQ or HOLD SHALL be ignored.

Reset
REQ-031 Asserting rst_n_i low SHALL, asynchronously and immediately:
  - set state=IDLE, fetch_pc=RESET_PC, kill=0, valid_q=0;
  - drive inst_o=0, pc_o=0, null_o=1, imem_req_o=0, imem_addr_o=RESET_PC.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; the memory is reset by the same rst_n_i and returns no stale rvalid.

Structure
REQ-033 The shared defines package SHALL hold the state encoding, RESET_PC default and instruction width; no other typedefs.
REQ-034 The block SHALL be a single module with no sub-module; the PC incrementer and next-PC mux stay inline.

Verification
REQ-035 Reset release, 1-cycle memory, keep=0:
  - requests SHALL go to 0x0, 0x4, 0x8;
  - the first null_o=0 SHALL occur 3 cycles after release with pc_o=0x0;
  - afterwards a new instruction SHALL appear every 2 cycles.
REQ-036 HOLD at pc 0x8 with keep_if_id_i=1 for 5 cycles:
  - inst_o/pc_o SHALL stay stable and imem_req_o SHALL stay 0;
  - on release, the request to 0xC SHALL issue in the same cycle.
REQ-037 Redirect to 0x100 while in WAIT with 3-cycle latency:
  - the response for the old PC SHALL be discarded;
  - the next request SHALL be to 0x100;
  - null_o SHALL stay 1 until the instruction at 0x100 arrives.
REQ-038 Redirect to 0x203 in the same cycle as imem_rvalid_i:
  - the data SHALL be dropped;
  - the next request SHALL be 0x200 in the following cycle.
REQ-039 Redirect during HOLD with keep=1:
  - null_o=1 on the next cycle;
  - the held instruction SHALL never transfer.
REQ-040 Reset asserted mid-WAIT then released:
  - outputs SHALL be at reset values while low;
  - fetch SHALL restart at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default reset fetch address and instruction word width.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_W           = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory bus between the fetch stage (master) and the memory
// (slave). Signal suffixes are named from the fetch stage's point of view.
interface if_stage_if;
    import if_stage_pkg::*;

    logic              imem_req_o;
    logic [31:0]       imem_addr_o;
    logic              imem_rvalid_i;
    logic [INST_W-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one memory request at a time, buffers the
// returned word for the decode register and handles downstream redirects.
// A redirect seen while a request is outstanding arms 'kill' so the stale
// response is dropped when it eventually arrives.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              keep_if_id_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    if_stage_if.master        imem,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_o,
    output logic              null_o
);

    fetch_state_e      state;
    logic [31:0]       fetch_pc;
    logic [31:0]       pc_plus4;
    logic [31:0]       redirect_aligned;
    logic              kill;
    logic [INST_W-1:0] inst_q;
    logic [31:0]       pc_q;
    logic              valid_q;
    logic              release_hold;

    // Sequential PC and word-aligned redirect target (32-bit modulo add).
    assign pc_plus4         = fetch_pc + 32'd4;
    assign redirect_aligned = redirect_pc_i & ~32'h0000_0003;

    // The held instruction leaves the buffer this cycle.
    assign release_hold = (state == ST_HOLD) && !keep_if_id_i;

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign null_o = ~valid_q;

    // Request strobe: in REQ, or in HOLD as the instruction transfers so the
    // next fetch overlaps the handoff; a redirect suppresses any request.
    always_comb begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = fetch_pc;
        if (!redirect_i) begin
            if (state == ST_REQ) begin
                imem.imem_req_o = 1'b1;
            end else if (release_hold) begin
                imem.imem_req_o  = 1'b1;
                imem.imem_addr_o = pc_plus4;
            end
        end
    end

    // Fetch FSM, fetch PC, kill flag and output buffer; redirect wins over
    // every other event.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
            valid_q  <= 1'b0;
            inst_q   <= '0;
            pc_q     <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_aligned;
            valid_q  <= 1'b0;
            if ((state == ST_WAIT) && !imem.imem_rvalid_i) begin
                // Response still pending: drop it when it shows up.
                kill <= 1'b1;
            end else begin
                kill  <= 1'b0;
                state <= ST_REQ;
            end
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ:  state <= ST_WAIT;
                ST_WAIT: begin
                    if (imem.imem_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            inst_q  <= imem.imem_rdata_i;
                            pc_q    <= fetch_pc;
                            valid_q <= 1'b1;
                            state   <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!keep_if_id_i) begin
                        fetch_pc <= pc_plus4;
                        valid_q  <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a latency-programmable memory model,
// scoreboard queues of expected transfers and requests, a vector table of
// redirect/fetch runs and hand-written corner-case sequences.
module tb_if_stage;
    import if_stage_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              keep_if_id_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic [INST_W-1:0] inst_o;
    logic [31:0]       pc_o;
    logic              null_o;

    if_stage_if imem_bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .keep_if_id_i  (keep_if_id_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem_bus),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .null_o        (null_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_req_q[$];
    int          xfer_cyc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return ~addr ^ 32'h0F0F_3C3C;
    endfunction

    // Memory model: one outstanding request, data returned mem_lat cycles
    // after the accepting edge, cleared by the shared reset.
    int          mem_lat = 1;
    logic        pend;
    int          remain;
    logic [31:0] mem_addr;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend     <= 1'b0;
            remain   <= 0;
            mem_addr <= '0;
        end else begin
            if (pend) begin
                if (remain == 1) pend <= 1'b0;
                else             remain <= remain - 1;
            end
            if (imem_bus.imem_req_o) begin
                pend     <= 1'b1;
                remain   <= mem_lat;
                mem_addr <= imem_bus.imem_addr_o;
            end
        end
    end

    assign imem_bus.imem_rvalid_i = pend && (remain == 1);
    assign imem_bus.imem_rdata_i  = (pend && (remain == 1)) ? mem_word(mem_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, then score transfers and requests.
    task automatic cycle(input logic k, input logic r, input logic [31:0] rpc);
        logic [31:0] e;
        @(negedge clk_i);
        keep_if_id_i  = k;
        redirect_i    = r;
        redirect_pc_i = rpc;
        #1;
        cyc++;
        if (!null_o && !keep_if_id_i) begin
            $display("xfer cyc=%0d pc=%h inst=%h", cyc, pc_o, inst_o);
            xfer_cyc_q.push_back(cyc);
            if (exp_pc_q.size() == 0) begin
                chk("xfer_unexpected", pc_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_pc_q.pop_front();
                chk("xfer_pc", pc_o, e);
                chk("xfer_inst", inst_o, mem_word(e));
            end
        end
        if (imem_bus.imem_req_o) begin
            $display("req  cyc=%0d addr=%h", cyc, imem_bus.imem_addr_o);
            if (exp_req_q.size() == 0) begin
                chk("req_unexpected", imem_bus.imem_addr_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_req_q.pop_front();
                chk("req_addr", imem_bus.imem_addr_o, e);
            end
        end
    endtask

    task automatic run_until_empty(input int budget);
        int b = 0;
        while ((exp_pc_q.size() != 0 || exp_req_q.size() != 0) && b < budget) begin
            cycle(exp_pc_q.size() == 0, 1'b0, 32'h0);
            b++;
        end
        chk("queue_drain", 32'(exp_pc_q.size() + exp_req_q.size()), 32'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_null"}, 32'(null_o), 32'd1);
        chk({tag, "_inst"}, inst_o, 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
        chk({tag, "_req"}, 32'(imem_bus.imem_req_o), 32'd0);
        chk({tag, "_addr"}, imem_bus.imem_addr_o, 32'h0000_0000);
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] first_pc;
        int          lat;
        int          n;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [31:0] p;

        vecs[0] = '{target: 32'h0000_1000, first_pc: 32'h0000_1000, lat: 1, n: 3};
        vecs[1] = '{target: 32'h0000_2002, first_pc: 32'h0000_2000, lat: 2, n: 2};
        vecs[2] = '{target: 32'hFFFF_FFF8, first_pc: 32'hFFFF_FFF8, lat: 1, n: 3};
        vecs[3] = '{target: 32'h0000_0047, first_pc: 32'h0000_0044, lat: 3, n: 2};

        rst_n_i       = 1'b0;
        keep_if_id_i  = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        chk_reset_outputs("rst");

        // Reset release with 1-cycle memory, then a 5-cycle stall at 0x8.
        mem_lat = 1;
        for (int i = 0; i < 3; i++) exp_pc_q.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) exp_req_q.push_back(32'(i * 4));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cyc = 0;
        xfer_cyc_q.delete();
        for (int c = 1; c <= 12; c++) begin
            cycle((c >= 7 && c <= 11), 1'b0, 32'h0);
            if (c >= 7 && c <= 11) begin
                chk("hold_pc", pc_o, 32'h8);
                chk("hold_inst", inst_o, mem_word(32'h8));
                chk("hold_null", 32'(null_o), 32'd0);
                chk("hold_req", 32'(imem_bus.imem_req_o), 32'd0);
            end
            if (c == 12) begin
                chk("release_req", 32'(imem_bus.imem_req_o), 32'd1);
                chk("release_addr", imem_bus.imem_addr_o, 32'hC);
            end
        end
        chk("xfer_count", 32'(xfer_cyc_q.size()), 32'd3);
        if (xfer_cyc_q.size() == 3) begin
            chk("first_xfer_cyc", 32'(xfer_cyc_q[0]), 32'd3);
            chk("second_xfer_cyc", 32'(xfer_cyc_q[1]), 32'd5);
            chk("third_xfer_cyc", 32'(xfer_cyc_q[2]), 32'd12);
        end
        settle(4);

        // Redirect to 0x100 while waiting on a 3-cycle memory.
        mem_lat = 3;
        exp_pc_q.push_back(32'hC);
        exp_req_q.push_back(32'h10);
        cycle(1'b0, 1'b0, 32'h0);
        exp_req_q.push_back(32'h100);
        exp_req_q.push_back(32'h104);
        exp_pc_q.push_back(32'h100);
        cycle(1'b1, 1'b1, 32'h100);
        run_until_empty(30);
        settle(6);

        // Redirect to 0x203 in the same cycle as the response.
        mem_lat = 1;
        exp_pc_q.push_back(32'h104);
        exp_req_q.push_back(32'h108);
        cycle(1'b0, 1'b0, 32'h0);
        exp_req_q.push_back(32'h200);
        cycle(1'b1, 1'b1, 32'h203);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_rv_req", 32'(imem_bus.imem_req_o), 32'd1);
        chk("redir_rv_addr", imem_bus.imem_addr_o, 32'h200);
        exp_pc_q.push_back(32'h200);
        exp_req_q.push_back(32'h204);
        run_until_empty(20);
        settle(4);

        // Table: redirect while holding with keep=1, then fetch n in order.
        for (int v = 0; v < 4; v++) begin
            mem_lat = vecs[v].lat;
            p = vecs[v].first_pc;
            for (int i = 0; i <= vecs[v].n; i++) begin
                if (i < vecs[v].n) exp_pc_q.push_back(p);
                exp_req_q.push_back(p);
                p = p + 32'd4;
            end
            cycle(1'b1, 1'b1, vecs[v].target);
            cycle(1'b0, 1'b0, 32'h0);
            chk("redir_hold_null", 32'(null_o), 32'd1);
            run_until_empty(60);
            settle(6);
        end

        // Reset in the middle of an outstanding 3-cycle request.
        mem_lat = 3;
        exp_pc_q.push_back(32'h4C);
        exp_req_q.push_back(32'h50);
        cycle(1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        keep_if_id_i = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk_i);
        #1;
        chk_reset_outputs("midrst_hold");
        mem_lat = 1;
        exp_pc_q.push_back(32'h0);
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h4);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_until_empty(20);
        settle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
